// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types and frame constants for the SPI register responder
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam int FRAME_BITS = 8;
    localparam int RW_BIT = 7;
    localparam logic [7:0] READ_FILL = 8'h00;

endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - pin synchronizer with registered level and rise/fall pulses
module spi_input_sync #(
    parameter int SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    // level is registered alongside the pulses so data pins line up with the clock pin's edge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_LEVEL}};
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            level <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~level;
            fall  <= ~chain[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/axil_spi_slave_regs.sv
// rtl/axil_spi_slave_regs.sv - SPI responder exposing an 8-bit register file to a remote master
module axil_spi_slave_regs
    import spi_slave_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       usr_wr_en,
    input  logic [6:0] usr_wr_addr,
    input  logic [7:0] usr_wr_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_strobe,
    output logic [6:0] rd_addr
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] REG_LIMIT = 8'(NUM_REGS);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    // CS resets to its active level so a frame already in progress at reset release is skipped
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_cs_sync (
        .clk(aclk), .reset(areset), .pin(spi_cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall));
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sclk_sync (
        .clk(aclk), .reset(areset), .pin(spi_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_mosi_sync (
        .clk(aclk), .reset(areset), .pin(spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_sync = &{1'b0, cs_level, sclk_level, sclk_fall, mosi_rise, mosi_fall};

    state_t                  state;
    logic [2:0]              bit_cnt;
    logic [7:0]              addr_sr;
    logic [FRAME_BITS-2:0]   data_sr;
    logic [7:0]              tx_sr;
    logic [7:0]              regs [NUM_REGS];

    logic [7:0] addr_next, data_next, read_load;
    logic       last_bit, commit;

    assign addr_next = {addr_sr[6:0], mosi_level};
    assign data_next = {data_sr, mosi_level};
    assign last_bit  = sclk_rise && (bit_cnt == 3'(FRAME_BITS - 1));
    assign commit    = (state == DATA) && !addr_sr[RW_BIT] && last_bit && !cs_rise;
    assign read_load = ({1'b0, addr_next[6:0]} < REG_LIMIT) ? regs[addr_next[IDX_W-1:0]] : READ_FILL;

    // Idle and write frames keep tx_sr all ones, so MISO rests high without extra muxing
    assign spi_miso = tx_sr[7];

    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (areset)
                regs[i] <= RESET_VALUE;
            else if (commit && addr_sr[6:0] == 7'(i))
                regs[i] <= data_next;
            else if (usr_wr_en && usr_wr_addr == 7'(i))
                regs[i] <= usr_wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            addr_sr   <= 8'h00;
            data_sr   <= '0;
            tx_sr     <= 8'hFF;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 8'h00;
            rd_addr   <= 7'd0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            if (cs_rise && state != IDLE) begin
                state <= IDLE;
                tx_sr <= 8'hFF;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= ADDR;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr_sr <= addr_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                state <= DATA;
                                if (addr_next[RW_BIT]) begin
                                    tx_sr     <= read_load;
                                    rd_strobe <= 1'b1;
                                    rd_addr   <= addr_next[6:0];
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (addr_sr[RW_BIT])
                                tx_sr <= {tx_sr[6:0], 1'b1};
                            else
                                data_sr <= data_next[FRAME_BITS-2:0];
                            if (last_bit) begin
                                state <= DONE;
                                if (!addr_sr[RW_BIT]) begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr_sr[6:0];
                                    wr_data   <= data_next;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axil_spi_slave_regs.sv
// tb/tb_axil_spi_slave_regs.sv - scoreboard bench for the SPI register responder
module tb_axil_spi_slave_regs;

    localparam int HALF = 8;
    localparam int GAP  = 8;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_sclk = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       usr_wr_en = 1'b0;
    logic [6:0] usr_wr_addr = 7'd0;
    logic [7:0] usr_wr_data = 8'h00;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_strobe;
    logic [6:0] rd_addr;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wr_q[$];
    logic [6:0] rd_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    axil_spi_slave_regs #(.NUM_REGS(16), .SYNC_STAGES(2), .RESET_VALUE(8'h00)) dut (
        .aclk(aclk), .areset(areset),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .usr_wr_en(usr_wr_en), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_strobe(rd_strobe), .rd_addr(rd_addr));

    always #5 aclk = ~aclk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    always @(negedge aclk) begin
        if (!areset) begin
            if (wr_strobe) begin
                if (wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_wr_strobe actual=%0h/%0h required=none", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", {25'd0, wr_addr}, {25'd0, e.a});
                    check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
                end
            end
            if (rd_strobe) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rd_strobe actual=%0h required=none", rd_addr);
                end else begin
                    check("rd_addr", {25'd0, rd_addr}, {25'd0, rd_q.pop_front()});
                end
            end
        end
        if (rx_valid) begin
            if (rx_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rx actual=%0h required=none", rx_byte);
            end else begin
                check("miso_byte", {24'd0, rx_byte}, {24'd0, rx_q.pop_front()});
            end
        end
    end

    task automatic spi_xfer(input logic [15:0] frame, input int nbits, input bit release_cs,
                            output logic [7:0] rx);
        rx = 8'h00;
        @(negedge aclk);
        spi_cs = 1'b0;
        repeat (HALF) @(negedge aclk);
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = frame[15-i];
            repeat (HALF) @(negedge aclk);
            if (i >= 8) rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge aclk);
        end
        if (release_cs) begin
            spi_cs = 1'b1;
            repeat (GAP) @(negedge aclk);
        end
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] rx;
        wr_q.push_back('{a: a, d: d});
        spi_xfer({1'b0, a, d}, 16, 1'b1, rx);
    endtask

    task automatic spi_read(input logic [6:0] a, input logic [7:0] exp);
        logic [7:0] rx;
        rd_q.push_back(a);
        rx_q.push_back(exp);
        spi_xfer({1'b1, a, 8'h00}, 16, 1'b1, rx);
        @(posedge aclk);
        rx_byte = rx;
        rx_valid = 1'b1;
        @(posedge aclk);
        rx_valid = 1'b0;
        @(negedge aclk);
        check("miso_after_read", {31'd0, spi_miso}, 32'd1);
    endtask

    task automatic usr_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge aclk);
        usr_wr_addr = a;
        usr_wr_data = d;
        usr_wr_en = 1'b1;
        @(negedge aclk);
        usr_wr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] dummy;
        repeat (5) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("reset_miso", {31'd0, spi_miso}, 32'd1);
        check("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("reset_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        check("reset_wr_addr", {25'd0, wr_addr}, 32'd0);
        check("reset_wr_data", {24'd0, wr_data}, 32'd0);
        check("reset_rd_addr", {25'd0, rd_addr}, 32'd0);
        repeat (GAP) @(negedge aclk);

        spi_write(7'h03, 8'hA5);
        spi_read(7'h03, 8'hA5);
        check("wr_addr_held", {25'd0, wr_addr}, 32'h3);
        check("wr_data_held", {24'd0, wr_data}, 32'hA5);

        usr_write(7'h05, 8'h3C);
        spi_read(7'h05, 8'h3C);

        spi_read(7'h7F, 8'h00);
        spi_write(7'h7F, 8'h12);
        spi_read(7'h03, 8'hA5);
        spi_read(7'h05, 8'h3C);

        usr_write(7'h02, 8'h77);
        spi_xfer({1'b0, 7'h02, 8'h99}, 12, 1'b1, dummy);
        spi_read(7'h02, 8'h77);
        spi_write(7'h02, 8'h11);
        spi_read(7'h02, 8'h11);

        wr_q.push_back('{a: 7'h04, d: 8'h55});
        fork
            spi_xfer({1'b0, 7'h04, 8'h55}, 16, 1'b1, dummy);
            begin
                int n;
                n = 0;
                @(negedge aclk);
                usr_wr_addr = 7'h04;
                usr_wr_data = 8'hAA;
                usr_wr_en = 1'b1;
                while (!wr_strobe && n < 2000) begin
                    @(negedge aclk);
                    n++;
                end
                usr_wr_en = 1'b0;
                check("collide_strobe_seen", {31'd0, wr_strobe}, 32'd1);
            end
        join
        spi_read(7'h04, 8'h55);

        rd_q.push_back(7'h05);
        spi_xfer({1'b1, 7'h05, 8'h00}, 9, 1'b0, dummy);
        repeat (HALF) @(negedge aclk);
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check("miso_in_reset", {31'd0, spi_miso}, 32'd1);
        areset = 1'b0;
        repeat (4) @(negedge aclk);
        check("miso_after_reset", {31'd0, spi_miso}, 32'd1);
        spi_cs = 1'b1;
        repeat (GAP) @(negedge aclk);
        spi_read(7'h05, 8'h00);
        spi_read(7'h03, 8'h00);
        spi_write(7'h07, 8'h42);
        spi_read(7'h07, 8'h42);

        repeat (10) @(negedge aclk);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("rd_queue_drained", rd_q.size(), 32'd0);
        check("rx_queue_drained", rx_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_spi_slave_regs.md
# axil_spi_slave_regs

SPI responder for the frame format driven by the AXI-Lite SPI master, exposing an 8-bit register file to a remote master. Each frame is one 8-bit address byte then one 8-bit data byte, MSB first. Address bit 7 selects the direction: 0 writes, 1 reads. The block sits on the target side of the link, and local logic reaches the register file through a parallel port.

## Interface
- NUM_REGS, 16: register count, 1..128; index is addr[6:0].
- SYNC_STAGES, 2: synchronizer depth on spi_cs/spi_sclk/spi_mosi, ≥2.
- RESET_VALUE, 8'h00: reset contents of every register.
- aclk  in  1  system clock; SPI pins oversampled; requires aclk ≥ 8× SCLK.
- areset  in  1  synchronous, active-high reset.
- spi_cs  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock, idles high.
- spi_mosi  in  1  master-to-slave data.
- spi_miso  out  1  slave-to-master data; 1 when not shifting read data.
- usr_wr_en  in  1  local register write strobe.
- usr_wr_addr  in  7  local write index.
- usr_wr_data  in  8  local write data.
- wr_strobe  out  1  1-cycle pulse when an SPI write commits.
- wr_addr  out  7  index of the committed SPI write; held until the next commit.
- wr_data  out  8  data of the committed SPI write; held until the next commit.
- rd_strobe  out  1  1-cycle pulse when a read address is latched.
- rd_addr  out  7  index of that read; held until the next read.

## Operation
- All SPI inputs pass through SYNC_STAGES flops. Edge detection on the synchronized signals gives cs_fall, cs_rise, sclk_rise.
- Bits are sampled on sclk_rise. The master changes MOSI while SCLK is low.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE → ADDR on cs_fall; bit counter cleared.
  - ADDR: shift MOSI into addr_sr on each sclk_rise. On the 8th rise, go to DATA.
    - If addr[7]=1, load tx_sr ← reg[addr[6:0]], or 8'h00 if the index ≥ NUM_REGS. Pulse rd_strobe.
  - DATA, write (addr[7]=0): shift MOSI into data_sr. On the 8th rise, commit reg[idx] ← data; pulse wr_strobe; go to DONE.
    - Index ≥ NUM_REGS: no register update, but wr_strobe still pulses.
  - DATA, read (addr[7]=1): spi_miso = tx_sr[7]. On each sclk_rise, shift tx_sr left with 1 fill. After the 8th rise, go to DONE.
  - DONE: further SCLK edges are ignored; spi_miso = 1.
- cs_rise from any non-IDLE state → IDLE.
  - Mid-frame abort: no commit and no wr_strobe.
  - A read abort after rd_strobe keeps that pulse as issued.
- Local write: reg[usr_wr_addr] ← usr_wr_data when usr_wr_en=1; index ≥ NUM_REGS is ignored.
- Same cycle, same index, SPI commit vs local write: the SPI commit wins.
- Read data is snapshotted at address latch. A later local write does not alter bits already in tx_sr.

## Timing
- Reset values: state IDLE, all registers RESET_VALUE, spi_miso=1, wr_strobe=0, rd_strobe=0, wr_addr=0, wr_data=0, rd_addr=0.
- Reset mid-frame returns to IDLE. A new frame starts only after a fresh cs_fall. If areset is released while spi_cs is already low, the current frame is ignored until CS is high again.
- Pin edge to internal edge pulse: SYNC_STAGES+1 aclk.
- wr_strobe asserts the cycle after the 16th sclk_rise pulse; the register updates on that same edge.
- tx_sr[7] is on spi_miso one cycle after the 8th sclk_rise pulse. It changes one cycle after each subsequent sclk_rise pulse.
  - Worst case is ≤ SYNC_STAGES+2 aclk after the pin edge.
  - This is within the half-period before the master samples, given aclk ≥ 8× SCLK.
- Back-to-back frames need a CS-high gap ≥ SYNC_STAGES+1 aclk; the master's pause phase satisfies this.

## Structure
- Package spi_slave_pkg holds:
  - state enum {IDLE, ADDR, DATA, DONE};
  - FRAME_BITS=8;
  - RW_BIT=7;
  - READ_FILL=8'h00.
- Sub-module spi_input_sync: SYNC_STAGES-flop synchronizer plus rise/fall pulse, one instance per input pin.
- Top contains the FSM, shift registers and register file (reg array, NUM_REGS×8).

## Test plan
- SPI write frame addr 8'h03, data 8'hA5 → wr_strobe once, wr_addr=3, wr_data=A5, reg[3]=A5.
- Local write reg[5]=8'h3C, then SPI read frame addr 8'h85 → rd_strobe, rd_addr=5, master captures 8'h3C; spi_miso=1 after the frame.
- SPI read addr 8'hFF with NUM_REGS=16 → master captures 8'h00. SPI write addr 8'h7F → wr_strobe pulses, no register changes.
- CS deasserted after 12 SCLK periods of a write to reg 2 → no wr_strobe, reg[2] unchanged; a following full frame to reg 2 with data 8'h11 → reg[2]=11.
- SPI commit to reg 4 (8'h55) in the same cycle as usr_wr_en to reg 4 (8'hAA) → reg[4]=55.
- areset pulsed during the DATA phase → all registers RESET_VALUE, spi_miso=1; the next complete frame operates normally.
